// File: rtl/audio_pkg.sv
// Shared constants and helpers for the I2S audio output path.
package audio_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int FRAME_SLOTS        = 32;
  localparam int LEFT_CAPTURE_SLOT  = 0;
  localparam int RIGHT_CAPTURE_SLOT = 16;
  localparam int DEFAULT_MCLK_LOG2  = 1;
  localparam int DEFAULT_SCK_LOG2   = 3;

  // Word-select polarity on the I2S bus: LRCK low carries left.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Bit of the hold register shifted in a given slot. The one-SCK I2S delay
  // makes slot g carry bit (16-g) mod 16 of its word, so slot 0 carries the
  // previous right word's LSB and slot 16 the left LSB.
  function automatic logic [3:0] slot_bit_index(input logic [4:0] slot);
    logic [4:0] diff;
    diff = 5'd16 - slot;
    return diff[3:0];
  endfunction

  // Slots 1..16 belong to the left word, everything else to the right word.
  function automatic channel_e slot_channel(input logic [4:0] slot);
    return ((slot >= 5'd1) && (slot <= 5'd16)) ? CH_LEFT : CH_RIGHT;
  endfunction

endpackage

// File: rtl/speaker_control.sv
// Serialises 16-bit stereo samples to a Pmod I2S DAC. One free-running
// counter provides MCLK, SCK and LRCK and schedules capture and shifting.
module speaker_control
  import audio_pkg::*;
#(
  parameter int MCLK_LOG2 = DEFAULT_MCLK_LOG2,
  parameter int SCK_LOG2  = DEFAULT_SCK_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_in_left,
  input  logic [SAMPLE_W-1:0] audio_in_right,
  input  logic                mute,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_ack
);

  localparam int CNT_W    = SCK_LOG2 + 6;
  localparam int SLOT_LSB = SCK_LOG2 + 1;
  localparam int SLOT_W   = $clog2(FRAME_SLOTS);

  // Capture happens on the last clk of the capture slot, just before the
  // counter enters the slot that carries the new word's MSB.
  localparam logic [CNT_W-1:0] LEFT_CAP_CNT  =
    CNT_W'(((LEFT_CAPTURE_SLOT + 1) << SLOT_LSB) - 1);
  localparam logic [CNT_W-1:0] RIGHT_CAP_CNT =
    CNT_W'(((RIGHT_CAPTURE_SLOT + 1) << SLOT_LSB) - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0] right_hold_q, right_hold_d;
  logic                sdin_q, sdin_d;
  logic                ack_q, ack_d;
  logic [SLOT_W-1:0]   slotNext;
  logic [3:0]          bitIdx;
  channel_e            slotChan;

  // Next-state logic: counter increment, per-channel capture and selection
  // of the serial bit for the slot the counter is about to enter. The bit is
  // taken from the next-state hold value so a freshly captured MSB leaves
  // immediately.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    ack_d        = 1'b0;
    if (cnt_q == LEFT_CAP_CNT) begin
      left_hold_d = mute ? '0 : audio_in_left;
      ack_d       = 1'b1;
    end
    if (cnt_q == RIGHT_CAP_CNT) begin
      right_hold_d = mute ? '0 : audio_in_right;
    end
    slotNext = cnt_d[CNT_W-1:SLOT_LSB];
    bitIdx   = slot_bit_index(slotNext);
    slotChan = slot_channel(slotNext);
    sdin_d   = (slotChan == CH_LEFT) ? left_hold_d[bitIdx] : right_hold_d[bitIdx];
  end

  // State registers with synchronous reset; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      sdin_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      sdin_q       <= sdin_d;
      ack_q        <= ack_d;
    end
  end

  assign audio_mclk = cnt_q[MCLK_LOG2];
  assign audio_sck  = cnt_q[SCK_LOG2];
  assign audio_lrck = cnt_q[CNT_W-1];
  assign audio_sdin = sdin_q;
  assign sample_ack = ack_q;

endmodule
